// File: rtl/rcc_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rcc_cfg_pkg: shared RCC config-path types and standard field map      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package rcc_cfg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_GATE   = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } rcc_sw_state_e;

  localparam int unsigned RCC_NUM_FIELDS = 24;
  localparam int unsigned RCC_CFG_W      = 64;
  localparam logic [RCC_CFG_W-1:0] RCC_RST_VAL = 64'h0;

  // Bit offsets of each field within the packed standard config word
  localparam int unsigned PLLSRC_OFS          = 0;
  localparam int unsigned PLLM_OFS            = 2;
  localparam int unsigned PLLN_OFS            = 8;
  localparam int unsigned PLLP_OFS            = 17;
  localparam int unsigned PLLQ_OFS            = 19;
  localparam int unsigned SW_OFS              = 23;
  localparam int unsigned HPRE_OFS            = 25;
  localparam int unsigned PPRE1_OFS           = 29;
  localparam int unsigned PPRE2_OFS           = 32;
  localparam int unsigned RTCPRE_OFS          = 35;
  localparam int unsigned MCO1_OFS            = 40;
  localparam int unsigned MCO1PRE_OFS         = 42;
  localparam int unsigned MCO2_OFS            = 45;
  localparam int unsigned MCO2PRE_OFS         = 47;
  localparam int unsigned I2SSRC_OFS          = 50;
  localparam int unsigned TIMPRE_OFS          = 51;
  localparam int unsigned MAC1_TXCLK_SEL_OFS  = 52;
  localparam int unsigned MAC1_RXCLK_SEL_OFS  = 53;
  localparam int unsigned MAC1_RCC_EPIS_OFS   = 54;
  localparam int unsigned MAC2_TXCLK_SEL_OFS  = 56;
  localparam int unsigned MAC2_RXCLK_SEL_OFS  = 57;
  localparam int unsigned MAC2_RCC_EPIS_OFS   = 58;
  localparam int unsigned MAC2_RCC_EPIS_1_OFS = 60;
  localparam int unsigned MAC2_RCC_EPIS_2_OFS = 62;

endpackage
`default_nettype wire

// File: rtl/rcc_sync_ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rcc_sync_ff: SYNC_STAGES-deep single-bit synchroniser                 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rcc_sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rcc_config_switch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rcc_config_switch: gated functional/test config source switch         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rcc_config_switch
  import rcc_cfg_pkg::*;
#(
  parameter int unsigned           NUM_FIELDS    = RCC_NUM_FIELDS,
  parameter int unsigned           CFG_W         = RCC_CFG_W,
  parameter logic [CFG_W-1:0]      RST_VAL       = CFG_W'(RCC_RST_VAL),
  parameter int unsigned           SYNC_STAGES   = 2,
  parameter int unsigned           GATE_CYCLES   = 4,
  parameter int unsigned           SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             atspeed_mode,
  input  logic [CFG_W-1:0] raw_cfg,
  input  logic [CFG_W-1:0] test_cfg,
  input  logic             upd_req,
  output logic             upd_ack,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_src,
  output logic             gate_req,
  output logic             busy,
  output logic             sw_done
);

  localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2 || GATE_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        NUM_FIELDS == 0 || NUM_FIELDS > CFG_W) begin : g_param_check
      $error("rcc_config_switch: illegal parameter set");
    end
  endgenerate

  logic mode_s;

  rcc_sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_mode_sync (
    .clk(clk),
    .rst(rst),
    .d  (atspeed_mode),
    .q  (mode_s)
  );

  rcc_sw_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_out_q, cfg_out_d;
  logic             cfg_src_q, cfg_src_d;
  logic             gate_req_q, gate_req_d;
  logic             upd_ack_q, upd_ack_d;
  logic             sw_done_q, sw_done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_out_d = cfg_out_q;
    cfg_src_d = cfg_src_q;
    upd_ack_d = 1'b0;
    sw_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A pending source change outranks any update request
        if (mode_s != cfg_src_q) begin
          state_d = ST_GATE;
          cnt_d   = GATE_LOAD;
        end else if (!cfg_src_q) begin
          if (upd_req) begin
            cfg_out_d = raw_cfg;
            upd_ack_d = 1'b1;
          end
        end else begin
          cfg_out_d = test_cfg;
          upd_ack_d = upd_req;
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        // Target is sampled here only; toggles during GATE do not abort
        cfg_out_d = mode_s ? test_cfg : raw_cfg;
        cfg_src_d = mode_s;
        state_d   = ST_SETTLE;
        cnt_d     = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d   = ST_RUN;
          sw_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    gate_req_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      cfg_out_q  <= RST_VAL;
      cfg_src_q  <= 1'b0;
      gate_req_q <= 1'b0;
      upd_ack_q  <= 1'b0;
      sw_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_out_q  <= cfg_out_d;
      cfg_src_q  <= cfg_src_d;
      gate_req_q <= gate_req_d;
      upd_ack_q  <= upd_ack_d;
      sw_done_q  <= sw_done_d;
    end
  end

  // Downstream parking spans every non-RUN state, so busy shares the flop
  assign cfg_out  = cfg_out_q;
  assign cfg_src  = cfg_src_q;
  assign gate_req = gate_req_q;
  assign busy     = gate_req_q;
  assign upd_ack  = upd_ack_q;
  assign sw_done  = sw_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rcc_config_switch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rcc_config_switch: directed self-checking bench                    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_rcc_config_switch;

  localparam logic [63:0] C_RST_VAL = 64'hA5;

  logic        clk;
  logic        rst;
  logic        atspeed_mode;
  logic [63:0] raw_cfg;
  logic [63:0] test_cfg;
  logic        upd_req;
  logic        upd_ack;
  logic [63:0] cfg_out;
  logic        cfg_src;
  logic        gate_req;
  logic        busy;
  logic        sw_done;

  int n_chk;
  int n_pass;

  rcc_config_switch #(
    .NUM_FIELDS   (24),
    .CFG_W        (64),
    .RST_VAL      (C_RST_VAL),
    .SYNC_STAGES  (2),
    .GATE_CYCLES  (4),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .atspeed_mode(atspeed_mode),
    .raw_cfg     (raw_cfg),
    .test_cfg    (test_cfg),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .cfg_out     (cfg_out),
    .cfg_src     (cfg_src),
    .gate_req    (gate_req),
    .busy        (busy),
    .sw_done     (sw_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int gh_cnt;
    int sw_cnt;
    int ack_cnt;
    int beef_idx;

    n_chk        = 0;
    n_pass       = 0;
    rst          = 1'b1;
    atspeed_mode = 1'b0;
    raw_cfg      = 64'h1;
    test_cfg     = 64'h0;
    upd_req      = 1'b0;

    // Reset values
    step(3);
    chk("rst_cfg_out", cfg_out, 64'hA5);
    chk("rst_cfg_src", 64'(cfg_src), 64'd0);
    chk("rst_gate_req", 64'(gate_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_upd_ack", 64'(upd_ack), 64'd0);
    chk("rst_sw_done", 64'(sw_done), 64'd0);
    rst = 1'b0;
    step(3);
    chk("idle_cfg_out", cfg_out, 64'hA5);
    chk("idle_gate_req", 64'(gate_req), 64'd0);

    // Functional update: one-cycle latency, no gating
    raw_cfg = 64'h1234;
    upd_req = 1'b1;
    step(1);
    chk("upd_cfg_out", cfg_out, 64'h1234);
    chk("upd_ack_pulse", 64'(upd_ack), 64'd1);
    chk("upd_gate_req", 64'(gate_req), 64'd0);
    upd_req = 1'b0;
    step(1);
    chk("upd_ack_drop", 64'(upd_ack), 64'd0);
    chk("upd_cfg_hold", cfg_out, 64'h1234);
    chk("upd_no_gate", 64'(gate_req), 64'd0);

    // Switch to test mode
    test_cfg     = 64'hBEEF;
    atspeed_mode = 1'b1;
    step(2);
    chk("sw1_gate_early", 64'(gate_req), 64'd0);
    step(1);
    chk("sw1_gate_rise", 64'(gate_req), 64'd1);
    chk("sw1_busy_rise", 64'(busy), 64'd1);
    gh_cnt   = 1;
    sw_cnt   = 0;
    beef_idx = -1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (gate_req) gh_cnt++;
      if (sw_done) sw_cnt++;
      if (beef_idx < 0 && cfg_out == 64'hBEEF) beef_idx = i;
    end
    chk("sw1_load_latency", 64'(beef_idx + 1), 64'd5);
    chk("sw1_gate_len", 64'(gh_cnt), 64'd9);
    chk("sw1_sw_done_cnt", 64'(sw_cnt), 64'd1);
    chk("sw1_cfg_src", 64'(cfg_src), 64'd1);
    chk("sw1_busy_end", 64'(busy), 64'd0);

    // Test mode follows test_cfg, ack without raw load
    test_cfg = 64'h1;
    step(1);
    chk("tm_follow1", cfg_out, 64'h1);
    test_cfg = 64'h2;
    chk("tm_lag", cfg_out, 64'h1);
    step(1);
    chk("tm_follow2", cfg_out, 64'h2);
    upd_req = 1'b1;
    step(1);
    chk("tm_upd_ack", 64'(upd_ack), 64'd1);
    chk("tm_upd_cfg", cfg_out, 64'h2);
    upd_req = 1'b0;
    step(1);
    chk("tm_upd_ack_drop", 64'(upd_ack), 64'd0);

    // Back to functional, bounce back to test during GATE
    raw_cfg      = 64'h55;
    atspeed_mode = 1'b0;
    step(3);
    chk("sw2_gate_rise", 64'(gate_req), 64'd1);
    step(3);
    chk("sw2_src_in_gate", 64'(cfg_src), 64'd1);
    atspeed_mode = 1'b1;
    step(2);
    chk("sw2_load_raw", cfg_out, 64'h55);
    chk("sw2_src_raw", 64'(cfg_src), 64'd0);
    chk("sw2_gate_held", 64'(gate_req), 64'd1);
    sw_cnt = 0;
    for (int i = 0; i < 28; i++) begin
      step(1);
      if (sw_done) sw_cnt++;
    end
    chk("sw2_sw_done_cnt", 64'(sw_cnt), 64'd2);
    chk("sw2_final_src", 64'(cfg_src), 64'd1);
    chk("sw2_final_cfg", cfg_out, 64'h2);
    chk("sw2_final_gate", 64'(gate_req), 64'd0);

    // Update request raised during SETTLE is deferred to RUN
    raw_cfg      = 64'h66;
    atspeed_mode = 1'b0;
    step(3);
    chk("sw3_gate_rise", 64'(gate_req), 64'd1);
    step(5);
    chk("sw3_load_raw", cfg_out, 64'h66);
    chk("sw3_src_raw", 64'(cfg_src), 64'd0);
    raw_cfg = 64'h77;
    upd_req = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (upd_ack) ack_cnt++;
    end
    chk("sw3_no_ack_busy", 64'(ack_cnt), 64'd0);
    chk("sw3_sw_done", 64'(sw_done), 64'd1);
    chk("sw3_cfg_pre_ack", cfg_out, 64'h66);
    step(1);
    chk("sw3_deferred_ack", 64'(upd_ack), 64'd1);
    chk("sw3_deferred_cfg", cfg_out, 64'h77);
    chk("sw3_busy_clear", 64'(busy), 64'd0);
    upd_req = 1'b0;
    step(1);
    chk("sw3_ack_drop", 64'(upd_ack), 64'd0);

    // Reset in the middle of GATE
    atspeed_mode = 1'b1;
    step(3);
    chk("rg_gate_rise", 64'(gate_req), 64'd1);
    step(1);
    rst = 1'b1;
    step(1);
    chk("rg_gate_drop", 64'(gate_req), 64'd0);
    chk("rg_cfg_out", cfg_out, 64'hA5);
    chk("rg_busy", 64'(busy), 64'd0);
    chk("rg_cfg_src", 64'(cfg_src), 64'd0);
    rst          = 1'b0;
    atspeed_mode = 1'b0;
    step(4);
    chk("rg_stay_run", 64'(gate_req), 64'd0);
    chk("rg_cfg_hold", cfg_out, 64'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rcc_config_switch.md
Name: rcc_config_switch

Overview:
- Parametrised, sequenced successor to the per-field functional/test config muxing in the RCC config path.
- Carries NUM_FIELDS packed config fields (select codes, prescalers, MAC flags) from functional registers or test-mode sources to the clock generators.
- Changes the driven source only through a gated switch sequence: park downstream dividers/switches, load, settle, release.
- Functional config updates are applied atomically through a req/ack handshake, so dividers never see a half-written config.

Parameters:
NUM_FIELDS, 24, number of config fields carried
CFG_W, 64, total packed width of all fields (field boundaries are not relevant to this block)
RST_VAL, 64'h0, cfg_out value during and after reset
SYNC_STAGES, 2, flops on atspeed_mode synchroniser (minimum 2)
GATE_CYCLES, 4, cycles gate_req is held before the load (minimum 1)
SETTLE_CYCLES, 4, cycles after the load before gate_req is released (minimum 1)

Ports:
clk  input  1  block clock
rst  input  1  synchronous reset, active-high
atspeed_mode  input  1  asynchronous test-mode select; 1 selects test_cfg
raw_cfg  input  CFG_W  functional config, packed
test_cfg  input  CFG_W  test-mode config, packed
upd_req  input  1  functional update request; level, held until ack
upd_ack  output  1  one-cycle pulse: raw_cfg was captured into cfg_out, or the request was absorbed
cfg_out  output  CFG_W  registered config to clock generators
cfg_src  output  1  source currently driving cfg_out (0 raw, 1 test)
gate_req  output  1  request downstream dividers/switches to park their outputs
busy  output  1  high in any state other than RUN
sw_done  output  1  one-cycle pulse when a switch sequence ends

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - cfg_out = RST_VAL
  - cfg_src = 0
  - gate_req = 0, busy = 0, upd_ack = 0, sw_done = 0
  - state = RUN, synchroniser flops cleared
- Synchroniser: atspeed_mode passes through SYNC_STAGES flops; mode_s is the last stage.
- FSM states: RUN, GATE, LOAD, SETTLE.
- RUN, in priority order:
  1. mode_s != cfg_src: go to GATE, load the counter with GATE_CYCLES-1, set gate_req and busy.
  2. cfg_src = 0 and upd_req = 1: load cfg_out <= raw_cfg and pulse upd_ack in the same cycle. Result: 1-cycle latency from upd_req to new cfg_out. No gating is used, since dividers are already built to accept glitch-free register updates.
  3. cfg_src = 1: cfg_out <= test_cfg every cycle (follows test_cfg with 1-cycle latency). If upd_req = 1, pulse upd_ack without changing cfg_out. The raw value is picked up when switching back to functional.
- GATE: decrement the counter; when it reaches 0, go to LOAD.
- LOAD (1 cycle): latch tgt = mode_s; cfg_out <= tgt ? test_cfg : raw_cfg; cfg_src <= tgt. Then go to SETTLE with the counter = SETTLE_CYCLES-1.
- SETTLE: count down to 0, then clear gate_req and busy, pulse sw_done, go to RUN.
- Fixed latency from the mode_s edge to the new cfg_out = GATE_CYCLES+1 cycles. gate_req is high for GATE_CYCLES+1+SETTLE_CYCLES cycles.
- mode_s toggling during GATE or SETTLE: the sequence is not aborted. The target is sampled in LOAD only. After SETTLE, RUN re-evaluates and starts a new sequence if mode_s != cfg_src. mode_s returning to the old value before LOAD results in a load of the same source (no source change) and still produces sw_done.
- upd_req while busy: no ack. The request stays pending and is served in the first RUN cycle where no switch is pending. The switch-back LOAD already captures the current raw_cfg.
- upd_req must be held until upd_ack. A second request needs upd_req to go low for at least one cycle, or it is re-acked each cycle (level semantics, documented).
- Reset asserted mid-sequence: immediate return to reset values next edge; gate_req drops without SETTLE.
- Counters are width $clog2(max(GATE_CYCLES,SETTLE_CYCLES))+1, with no wrap: the counter saturates at 0.

Decomposition:
- Shared package rcc_cfg_pkg: FSM state enum (RUN/GATE/LOAD/SETTLE), CFG_W and the field-offset localparams for the standard RCC field map (pllsrc..mac2_rcc_epis_2), and RST_VAL for the standard map.
- One sub-module, rcc_sync_ff (parametrised SYNC_STAGES bit synchroniser), reusable across RCC.

Test Plan:
1. Reset with RST_VAL=64'hA5, raw_cfg=64'h1 -> cfg_out=64'hA5, cfg_src=0, gate_req=0; after rst release with upd_req=0, cfg_out stays 64'hA5.
2. In RUN functional, raw_cfg=64'h1234, upd_req 1 for 1 cycle -> next edge cfg_out=64'h1234, upd_ack pulse 1 cycle, gate_req never asserts.
3. atspeed_mode 0->1 with test_cfg=64'hBEEF, defaults -> gate_req rises SYNC_STAGES+1 edges after the input; cfg_out=64'hBEEF 5 cycles after gate_req rises; gate_req high 9 cycles total; sw_done pulses once; cfg_src=1.
4. In test mode, test_cfg steps 64'h1 then 64'h2 -> cfg_out follows with 1-cycle lag; upd_req=1 -> upd_ack pulse, cfg_out unchanged.
5. atspeed_mode 1->0, then back to 1 during GATE -> the first sequence loads raw (cfg_src=0), sw_done, then a second sequence restores test; two sw_done pulses total.
6. upd_req raised during SETTLE with raw_cfg=64'h77 -> no ack until RUN; upd_ack pulses on the first RUN cycle, cfg_out=64'h77. Also: rst asserted during GATE -> gate_req=0 and cfg_out=RST_VAL on the next edge.
